// File: rtl/stream_serializer_pkg.sv
// ============================================================================
// Module   : stream_serializer_pkg
// Purpose  : Shared helpers for the wide-to-narrow stream serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_serializer_pkg;

  // Maps a beat number onto the word slice it carries.
  function automatic int unsigned beat_slice(input int unsigned cnt,
                                             input int unsigned num_beats,
                                             input bit          msb_first);
    return msb_first ? (num_beats - 1 - cnt) : cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_serializer.sv
// ============================================================================
// Module   : stream_serializer
// Purpose  : Splits wide valid/ready words into up to NumBeats narrow beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned NumBeats  = 4,
  parameter bit          MsbFirst  = 1'b0,
  parameter int unsigned LenWidth  = $clog2(NumBeats)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DataWidth*NumBeats-1:0] in_data_i,
  input  logic [LenWidth-1:0]           in_len_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [DataWidth-1:0]          out_data_o,
  output logic                          out_last_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o
);

  typedef enum logic [0:0] {
    Idle = 1'b0,
    Send = 1'b1
  } state_e;

  localparam logic [LenWidth:0]   MaxLenExt = (LenWidth + 1)'(NumBeats - 1);
  localparam logic [LenWidth-1:0] MaxLen    = LenWidth'(NumBeats - 1);

  state_e                              state_q, state_d;
  logic [NumBeats-1:0][DataWidth-1:0]  data_q, data_d;
  logic [LenWidth-1:0]                 len_q, len_d;
  logic [LenWidth-1:0]                 cnt_q, cnt_d;
  logic [LenWidth-1:0]                 sel_idx;
  logic                                is_last;
  logic                                in_hs;
  logic                                out_hs;

  assign sel_idx    = LenWidth'(beat_slice(32'(cnt_q), NumBeats, MsbFirst));
  assign out_data_o = data_q[sel_idx];
  assign busy_o     = (state_q == Send);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    len_d       = len_q;
    cnt_d       = cnt_q;

    out_valid_o = (state_q == Send);
    is_last     = out_valid_o && (cnt_q == len_q);
    out_last_o  = is_last;
    out_hs      = out_valid_o && out_ready_i;
    // Ready opens in the same cycle the last beat leaves, so words stream without a bubble.
    in_ready_o  = !rst_i && ((state_q == Idle) || (out_hs && is_last));
    in_hs       = in_valid_i && in_ready_o;

    if (in_hs) begin
      state_d = Send;
      data_d  = in_data_i;
      len_d   = ({1'b0, in_len_i} > MaxLenExt) ? MaxLen : in_len_i;
      cnt_d   = '0;
    end else if (out_hs) begin
      if (is_last) begin
        state_d = Idle;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_serializer.sv
// ============================================================================
// Module   : tb_stream_serializer
// Purpose  : Self-checking bench for stream_serializer (table + random model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_len;
  logic        in_valid;
  logic        out_ready;

  logic        ir0, ol0, ov0, busy0;
  logic [7:0]  od0;
  logic        ir1, ol1, ov1, busy1;
  logic [7:0]  od1;

  logic [23:0] c_data;
  logic [1:0]  c_len;
  logic        c_valid, c_ir, c_ol, c_ov, c_busy;
  logic [7:0]  c_od;

  int checks   = 0;
  int failures = 0;

  stream_serializer #(.DataWidth(8), .NumBeats(4), .MsbFirst(1'b0)) dut_lsb (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_len_i(in_len),
    .in_valid_i(in_valid), .in_ready_o(ir0), .out_data_o(od0), .out_last_o(ol0),
    .out_valid_o(ov0), .out_ready_i(out_ready), .busy_o(busy0)
  );

  stream_serializer #(.DataWidth(8), .NumBeats(4), .MsbFirst(1'b1)) dut_msb (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_len_i(in_len),
    .in_valid_i(in_valid), .in_ready_o(ir1), .out_data_o(od1), .out_last_o(ol1),
    .out_valid_o(ov1), .out_ready_i(out_ready), .busy_o(busy1)
  );

  // Three beats per word: lengths of 3 must clamp to 2.
  stream_serializer #(.DataWidth(8), .NumBeats(3), .MsbFirst(1'b0)) dut_nb3 (
    .clk_i(clk), .rst_i(rst), .in_data_i(c_data), .in_len_i(c_len),
    .in_valid_i(c_valid), .in_ready_o(c_ir), .out_data_o(c_od), .out_last_o(c_ol),
    .out_valid_o(c_ov), .out_ready_i(out_ready), .busy_o(c_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] data;
    logic [1:0]  len;
    bit          iv;
    bit          ordy;
    bit          e_ir;
    bit          e_ov;
    bit          chk_d;
    logic [7:0]  e_od;
    bit          e_last;
    bit          e_busy;
  } vec_t;

  function automatic vec_t mk(bit r, logic [31:0] d, logic [1:0] l, bit iv, bit ordy,
                              bit e_ir, bit e_ov, bit chk_d, logic [7:0] e_od,
                              bit e_last, bit e_busy);
    vec_t v;
    v.rst = r; v.data = d; v.len = l; v.iv = iv; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.chk_d = chk_d; v.e_od = e_od;
    v.e_last = e_last; v.e_busy = e_busy;
    return v;
  endfunction

  typedef struct {
    logic [7:0] d_lsb;
    logic [7:0] d_msb;
    bit         last;
  } beat_t;

  vec_t  vecs[$];
  beat_t model_q[$];

  initial begin
    rst = 1'b1; in_data = '0; in_len = '0; in_valid = 1'b0; out_ready = 1'b1;
    c_data = '0; c_len = '0; c_valid = 1'b0;

    // Reset, full word, back-to-back short words, backpressure, reset mid-word.
    vecs.push_back(mk(1, 32'hDEADBEEF, 3, 1, 1,  0, 0, 1, 8'h00, 0, 0));
    vecs.push_back(mk(1, 32'hDEADBEEF, 3, 1, 1,  0, 0, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 32'h44332211, 3, 1, 1,  1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  0, 1, 1, 8'h11, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  0, 1, 1, 8'h22, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  0, 1, 1, 8'h33, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  1, 1, 1, 8'h44, 1, 1));
    vecs.push_back(mk(0, 32'h0000BBAA, 1, 1, 1,  1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 32'h0000DDCC, 1, 1, 1,  0, 1, 1, 8'hAA, 0, 1));
    vecs.push_back(mk(0, 32'h0000DDCC, 1, 1, 1,  1, 1, 1, 8'hBB, 1, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  0, 1, 1, 8'hCC, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  1, 1, 1, 8'hDD, 1, 1));
    vecs.push_back(mk(0, 32'h44332211, 3, 1, 1,  1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  0, 1, 1, 8'h11, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0,  0, 1, 1, 8'h22, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0,  0, 1, 1, 8'h22, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0,  0, 1, 1, 8'h22, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  0, 1, 1, 8'h22, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  0, 1, 1, 8'h33, 0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  1, 1, 1, 8'h44, 1, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 32'h44332211, 3, 1, 1,  1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  0, 1, 1, 8'h11, 0, 1));
    vecs.push_back(mk(1, 32'h0,        0, 0, 1,  0, 1, 1, 8'h22, 0, 1));
    vecs.push_back(mk(0, 32'h88776655, 3, 1, 1,  1, 0, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1,  0, 1, 1, 8'h55, 0, 1));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_data = vecs[i].data; in_len = vecs[i].len;
      in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(ir0), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(ov0), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_out_last", i), 32'(ol0), 32'(vecs[i].e_last));
      chk($sformatf("vec%0d_busy", i), 32'(busy0), 32'(vecs[i].e_busy));
      if (vecs[i].chk_d) chk($sformatf("vec%0d_out_data", i), 32'(od0), 32'(vecs[i].e_od));
    end

    // MsbFirst short word: only the upper slices go out, highest first.
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); rst = 1'b0; in_valid = 1'b1; in_data = 32'h44332211; in_len = 2'd1;
    #1 chk("msb_in_ready", 32'(ir1), 32'd1);
    @(negedge clk); in_valid = 1'b0;
    #1 chk("msb_beat0_data", 32'(od1), 32'h44); chk("msb_beat0_last", 32'(ol1), 32'd0);
    chk("msb_beat0_valid", 32'(ov1), 32'd1);
    @(negedge clk);
    #1 chk("msb_beat1_data", 32'(od1), 32'h33); chk("msb_beat1_last", 32'(ol1), 32'd1);
    @(negedge clk);
    #1 chk("msb_done_valid", 32'(ov1), 32'd0);

    // Length clamp on a three-beat serializer.
    @(negedge clk); c_valid = 1'b1; c_data = 24'hCCBBAA; c_len = 2'd3;
    #1 chk("clamp_in_ready", 32'(c_ir), 32'd1);
    @(negedge clk); c_valid = 1'b0;
    #1 chk("clamp_b0", 32'(c_od), 32'hAA); chk("clamp_b0_last", 32'(c_ol), 32'd0);
    @(negedge clk);
    #1 chk("clamp_b1", 32'(c_od), 32'hBB); chk("clamp_b1_last", 32'(c_ol), 32'd0);
    @(negedge clk);
    #1 chk("clamp_b2", 32'(c_od), 32'hCC); chk("clamp_b2_last", 32'(c_ol), 32'd1);
    @(negedge clk);
    #1 chk("clamp_done_valid", 32'(c_ov), 32'd0);

    // Random traffic against a queue-of-beats reference model.
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit e_ov, e_ir;
      @(negedge clk);
      rst       = (cyc == 0) || ($urandom_range(0, 99) < 2);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_len    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      #1;
      e_ov = (model_q.size() != 0);
      e_ir = !rst && ((model_q.size() == 0) || (model_q.size() == 1 && out_ready));
      if (cyc > 0) begin
        chk("rnd_in_ready", 32'(ir0), 32'(e_ir));
        chk("rnd_out_valid", 32'(ov0), 32'(e_ov));
        chk("rnd_busy", 32'(busy0), 32'(e_ov));
        chk("rnd_msb_valid", 32'(ov1), 32'(e_ov));
        if (e_ov) begin
          chk("rnd_data_lsb", 32'(od0), 32'(model_q[0].d_lsb));
          chk("rnd_data_msb", 32'(od1), 32'(model_q[0].d_msb));
          chk("rnd_last_lsb", 32'(ol0), 32'(model_q[0].last));
          chk("rnd_last_msb", 32'(ol1), 32'(model_q[0].last));
        end else begin
          chk("rnd_idle_last", 32'(ol0), 32'd0);
        end
      end
      @(posedge clk);
      if (rst) begin
        model_q.delete();
      end else begin
        if (e_ov && out_ready) void'(model_q.pop_front());
        if (in_valid && e_ir) begin
          for (int b = 0; b <= int'(in_len); b++) begin
            beat_t bt;
            bt.d_lsb = in_data[b*8 +: 8];
            bt.d_msb = in_data[(3-b)*8 +: 8];
            bt.last  = (b == int'(in_len));
            model_q.push_back(bt);
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
